load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  1  memory op requested; address is the ALU result this cycle.
REQ-004 req_write  in  1  1 = store, 0 = load.
REQ-005 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-006 addr  in  32  byte address from ALU result.
REQ-007 wdata  in  32  store data (rs2), right-aligned.
REQ-008 req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-009 stall  out  1  = req_valid || (state != IDLE); holds core PC/pipeline.
REQ-010 mem_req / mem_we  out  1 / 1  bus request and write strobe, registered.
REQ-011 mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}, registered.
REQ-012 mem_wdata / mem_be  out  32 / 4  lane-aligned store data and byte enables, registered.
REQ-013 mem_gnt / mem_rvalid  in  1 / 1  bus grant; read data valid.
REQ-014 mem_rdata  in  32  read word, valid with mem_rvalid.
REQ-015 rsp_valid  out  1  single-cycle completion pulse.
REQ-016 rsp_rdata / rsp_err  out  32 / 1  extended load data; misaligned or illegal op flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-018 IDLE: accepted legal request -> REQ next cycle with all mem_* outputs loaded; accepted illegal/misaligned request -> RESP with rsp_err=1, no bus access.
REQ-019 Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-020 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=00; B never misaligned.
REQ-021 REQ: mem_req held high with stable mem_* until mem_gnt; on gnt store -> RESP, load -> WAIT; mem_req low in all other states.
REQ-022 WAIT: on mem_rvalid capture extracted data -> RESP; mem_rvalid in any other state ignored.
REQ-023 RESP: rsp_valid=1 for exactly one cycle -> IDLE; rsp_rdata/rsp_err hold until next RESP.
REQ-024 Store lanes: SB be=4'b0001<<addr[1:0], wdata[7:0] replicated in all 4 bytes; SH be=0011 (addr[1]=0) or 1100, wdata[15:0] replicated in both halves; SW be=1111, wdata unchanged.
REQ-025 Load extract: shift mem_rdata right by 8*addr[1:0]; B/H sign-extend bit 7/15, BU/HU zero-extend, W unchanged; stores return rsp_rdata=0.
REQ-026 Latency: store with gnt on first REQ cycle -> rsp_valid 2 cycles after accept; load with gnt then rvalid next cycle -> 3 cycles; error -> 1 cycle.
REQ-027 req_valid while req_ready=0 SHALL be ignored (no queuing); core holds it via stall.
REQ-028 mem_gnt and mem_rvalid in same REQ cycle: grant honoured, rvalid ignored, WAIT entered.

Reset
REQ-029 rst SHALL force IDLE; mem_req, mem_we, rsp_valid, rsp_err = 0; mem_addr, mem_wdata, rsp_rdata = 0; mem_be = 0000.
REQ-030 rst in REQ or WAIT SHALL abort without rsp_valid; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-031 SW addr=0x100 wdata=0xDEADBEEF, gnt immediate -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-032 LB addr=0x103, rdata=0x80FF_0000 -> rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr=0x102 wdata=0x0000_1234 -> be=1100, mem_wdata=0x12341234; LHU addr=0x102 rdata=0xABCD0000 -> 0x0000ABCD.
REQ-034 LW addr=0x101 -> no mem_req, rsp_valid next cycle with rsp_err=1; load funct3=011 -> same.
REQ-035 gnt delayed 3 cycles -> mem_req/mem_addr stable throughout, stall=1, req_ready=0; rsp after rvalid.
REQ-036 rst asserted in WAIT, then mem_rvalid -> outputs at reset values, no rsp_valid, next request served normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core/memory-facing signal bundle of the load/store unit.
// The slave modport is the LSU view; the master modport is the core plus memory environment.
interface load_store_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = XLEN / 8;

  // Core request side
  logic              req_valid;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              req_ready;
  logic              stall;

  // Memory bus side
  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [BEW-1:0]    mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  // Completion side
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_write, req_funct3, addr, wdata,
    output req_ready, stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_write, req_funct3, addr, wdata,
    input  req_ready, stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, lane alignment for stores,
// extraction and extension for loads, early error response for bad requests.
module load_store_unit (
  input  logic             clk,
  input  logic             rst,
  load_store_unit_if.slave lsu
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q,     state_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]  mem_be_q,    mem_be_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q,   rsp_err_d;
  logic [2:0]      funct3_q,    funct3_d;
  logic [1:0]      off_q,       off_d;
  logic            write_q,     write_d;

  logic            req_err_c;
  logic [BEW-1:0]  st_be_c;
  logic [XLEN-1:0] st_wdata_c;
  logic [XLEN-1:0] shifted_c;
  logic [XLEN-1:0] load_data_c;

  // Request legality/alignment and store lane placement
  always_comb begin : req_decode
    req_err_c  = 1'b0;
    st_be_c    = '0;
    st_wdata_c = '0;
    if (lsu.req_write) begin
      case (lsu.req_funct3)
        3'b000: begin
          st_be_c    = BEW'(4'b0001 << lsu.addr[1:0]);
          st_wdata_c = {4{lsu.wdata[7:0]}};
        end
        3'b001: begin
          st_be_c    = lsu.addr[1] ? 4'b1100 : 4'b0011;
          st_wdata_c = {2{lsu.wdata[15:0]}};
          req_err_c  = lsu.addr[0];
        end
        3'b010: begin
          st_be_c    = 4'b1111;
          st_wdata_c = lsu.wdata;
          req_err_c  = |lsu.addr[1:0];
        end
        default: req_err_c = 1'b1;
      endcase
    end else begin
      case (lsu.req_funct3)
        3'b000, 3'b100: req_err_c = 1'b0;
        3'b001, 3'b101: req_err_c = lsu.addr[0];
        3'b010:         req_err_c = |lsu.addr[1:0];
        default:        req_err_c = 1'b1;
      endcase
    end
  end

  // Load data: bring the addressed byte/half to bit 0, then extend
  always_comb begin : load_extract
    shifted_c   = lsu.mem_rdata >> {off_q, 3'b000};
    load_data_c = shifted_c;
    case (funct3_q)
      3'b000:  load_data_c = {{24{shifted_c[7]}},  shifted_c[7:0]};
      3'b100:  load_data_c = {24'd0,               shifted_c[7:0]};
      3'b001:  load_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  load_data_c = {16'd0,               shifted_c[15:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin : fsm_next
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    write_d     = write_q;

    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          funct3_d = lsu.req_funct3;
          off_d    = lsu.addr[1:0];
          write_d  = lsu.req_write;
          if (req_err_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = lsu.req_write;
            mem_addr_d  = {lsu.addr[XLEN-1:2], 2'b00};
            mem_wdata_d = st_wdata_c;
            mem_be_d    = st_be_c;
          end
        end
      end
      REQ: begin
        if (lsu.mem_gnt) begin
          if (write_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d = WAIT;
          end
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = write_q;
        end
      end
      WAIT: begin
        if (lsu.mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = load_data_c;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      write_q     <= write_d;
    end
  end

  // Handshake outputs decode directly from state so the core sees them the same cycle
  assign lsu.req_ready = (state_q == IDLE);
  assign lsu.stall     = lsu.req_valid || (state_q != IDLE);

  assign lsu.mem_req   = mem_req_q;
  assign lsu.mem_we    = mem_we_q;
  assign lsu.mem_addr  = mem_addr_q;
  assign lsu.mem_wdata = mem_wdata_q;
  assign lsu.mem_be    = mem_be_q;
  assign lsu.rsp_valid = rsp_valid_q;
  assign lsu.rsp_rdata = rsp_rdata_q;
  assign lsu.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions, an
// operation-level model for expected bus/response values, per-cycle compare.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if lsu ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs, maintained by the stimulus from the protocol timeline
  logic        chk_en = 1'b0;
  logic        exp_ready;
  logic        exp_mem_req;
  logic        exp_mem_we;
  logic        exp_store;
  logic [31:0] exp_mem_addr;
  logic [31:0] exp_mem_wdata;
  logic [3:0]  exp_mem_be;
  logic        exp_rsp_valid;
  logic [31:0] exp_rsp_rdata;
  logic        exp_rsp_err;

  // Values observed during the last transaction, for literal pinning
  logic        snap_req;
  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic [3:0]  snap_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- operation-level model ----------------
  function automatic logic model_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    int   size;
    if (w) legal = f3 inside {3'b000, 3'b001, 3'b010};
    else   legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    size = 1 << f3[1:0];
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int size = 1 << f3[1:0];
    int off  = int'(a[1:0]);
    for (int i = 0; i < 4; i++) be[i] = ((i / size) == (off / size));
    return be;
  endfunction

  function automatic logic [31:0] model_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int size = 1 << f3[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    logic [31:0] r;
    int nbits = 8 * (1 << f3[1:0]);
    v = rd >> (8 * int'(a[1:0]));
    r = '0;
    for (int i = 0; i < nbits; i++) r[i] = v[i];
    if (!f3[2]) for (int i = nbits; i < 32; i++) r[i] = v[nbits-1];
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(lsu.req_ready), 32'(exp_ready));
      chk("stall",     32'(lsu.stall),     32'(lsu.req_valid || !exp_ready));
      chk("mem_req",   32'(lsu.mem_req),   32'(exp_mem_req));
      if (exp_mem_req) begin
        chk("mem_addr", lsu.mem_addr,     exp_mem_addr);
        chk("mem_we",   32'(lsu.mem_we),  32'(exp_mem_we));
        if (exp_store) begin
          chk("mem_be",    32'(lsu.mem_be), 32'(exp_mem_be));
          chk("mem_wdata", lsu.mem_wdata,   exp_mem_wdata);
        end
      end
      chk("rsp_valid", 32'(lsu.rsp_valid), 32'(exp_rsp_valid));
      chk("rsp_rdata", lsu.rsp_rdata,      exp_rsp_rdata);
      chk("rsp_err",   32'(lsu.rsp_err),   32'(exp_rsp_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp_idle_reset();
    exp_ready     = 1'b1;
    exp_mem_req   = 1'b0;
    exp_mem_we    = 1'b0;
    exp_store     = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_rsp_rdata = '0;
    exp_rsp_err   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},     32'(lsu.req_ready), 32'd1);
    chk({tag, "_mem_req"},   32'(lsu.mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(lsu.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  lsu.mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, lsu.mem_wdata,      32'd0);
    chk({tag, "_mem_be"},    32'(lsu.mem_be),    32'd0);
    chk({tag, "_rsp_valid"}, 32'(lsu.rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, lsu.rsp_rdata,      32'd0);
    chk({tag, "_rsp_err"},   32'(lsu.rsp_err),   32'd0);
  endtask

  // One complete transaction following the expected bus timeline
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int gnt_delay, input logic rv_with_gnt,
                       input int rv_delay, input logic [31:0] rd, input logic hold_valid);
    logic err;
    err            = model_err(w, f3, a);
    lsu.req_valid  = 1'b1;
    lsu.req_write  = w;
    lsu.req_funct3 = f3;
    lsu.addr       = a;
    lsu.wdata      = wd;
    step();
    snap_req   = lsu.mem_req;
    snap_addr  = lsu.mem_addr;
    snap_wdata = lsu.mem_wdata;
    snap_be    = lsu.mem_be;
    if (hold_valid) begin
      lsu.addr  = ~a;
      lsu.wdata = ~wd;
    end else begin
      lsu.req_valid = 1'b0;
    end
    if (err) begin
      lsu.req_valid = 1'b0;
      exp_ready     = 1'b0;
      exp_rsp_valid = 1'b1;
      exp_rsp_err   = 1'b1;
      exp_rsp_rdata = '0;
      step();
      exp_ready     = 1'b1;
      exp_rsp_valid = 1'b0;
      return;
    end
    exp_ready     = 1'b0;
    exp_mem_req   = 1'b1;
    exp_mem_we    = w;
    exp_store     = w;
    exp_mem_addr  = a & ~32'd3;
    exp_mem_be    = model_be(f3, a);
    exp_mem_wdata = model_lanes(f3, wd);
    repeat (gnt_delay) step();
    lsu.mem_gnt    = 1'b1;
    lsu.mem_rvalid = rv_with_gnt;
    lsu.mem_rdata  = ~rd;
    step();
    lsu.mem_gnt    = 1'b0;
    lsu.mem_rvalid = 1'b0;
    exp_mem_req    = 1'b0;
    if (!w) begin
      repeat (rv_delay) step();
      lsu.mem_rvalid = 1'b1;
      lsu.mem_rdata  = rd;
      step();
      lsu.mem_rvalid = 1'b0;
      lsu.mem_rdata  = 32'h5A5A_5A5A;
      exp_rsp_rdata  = model_load(f3, a, rd);
    end else begin
      exp_rsp_rdata  = '0;
    end
    lsu.req_valid = 1'b0;
    exp_rsp_valid = 1'b1;
    exp_rsp_err   = 1'b0;
    step();
    exp_ready     = 1'b1;
    exp_rsp_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst            = 1'b1;
    lsu.req_valid  = 1'b0;
    lsu.req_write  = 1'b0;
    lsu.req_funct3 = 3'b000;
    lsu.addr       = '0;
    lsu.wdata      = '0;
    lsu.mem_gnt    = 1'b0;
    lsu.mem_rvalid = 1'b0;
    lsu.mem_rdata  = '0;
    exp_mem_addr   = '0;
    exp_mem_wdata  = '0;
    exp_mem_be     = '0;
    set_exp_idle_reset();
    step();
    step();
    check_reset_values("por");
    rst    = 1'b0;
    chk_en = 1'b1;
    step();

    // SW aligned, immediate grant
    do_op(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("sw_addr",  snap_addr,        32'h0000_0100);
    chk("sw_be",    32'(snap_be),     32'hF);
    chk("sw_wdata", snap_wdata,       32'hDEAD_BEEF);
    chk("sw_err",   32'(lsu.rsp_err), 32'd0);

    // LB / LBU top byte
    do_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0, 0, 32'h80FF_0000, 1'b0);
    chk("lb_data",  lsu.rsp_rdata, 32'hFFFF_FF80);
    do_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 1'b0, 0, 32'h80FF_0000, 1'b0);
    chk("lbu_data", lsu.rsp_rdata, 32'h0000_0080);

    // SH upper half, LHU upper half
    do_op(1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("sh_be",    32'(snap_be), 32'hC);
    chk("sh_wdata", snap_wdata,   32'h1234_1234);
    chk("sh_rdata", lsu.rsp_rdata, 32'h0);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 0, 1'b0, 0, 32'hABCD_0000, 1'b0);
    chk("lhu_data", lsu.rsp_rdata, 32'h0000_ABCD);

    // Misaligned LW and illegal load funct3: no bus access
    do_op(1'b0, 3'b010, 32'h101, 32'h0, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("lw_mis_req", 32'(snap_req),     32'd0);
    chk("lw_mis_err", 32'(lsu.rsp_err),  32'd1);
    do_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("ld011_req", 32'(snap_req),    32'd0);
    chk("ld011_err", 32'(lsu.rsp_err), 32'd1);

    // Delayed grant and read data, request held while busy
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 3, 1'b0, 2, 32'h1357_9BDF, 1'b1);
    chk("lw_slow_data", lsu.rsp_rdata, 32'h1357_9BDF);

    // Grant and rvalid together: rvalid ignored
    do_op(1'b0, 3'b001, 32'h202, 32'h0, 0, 1'b1, 1, 32'h8001_0000, 1'b0);
    chk("lh_data", lsu.rsp_rdata, 32'hFFFF_8001);

    // SB lane 1, illegal store funct3, misaligned SH, positive LB
    do_op(1'b1, 3'b000, 32'h101, 32'h0000_00AB, 1, 1'b0, 0, 32'h0, 1'b0);
    chk("sb_be",    32'(snap_be), 32'h2);
    chk("sb_wdata", snap_wdata,   32'hABAB_ABAB);
    do_op(1'b1, 3'b100, 32'h100, 32'h1, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("st100_err", 32'(lsu.rsp_err), 32'd1);
    do_op(1'b1, 3'b001, 32'h103, 32'h1, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("sh_mis_err", 32'(lsu.rsp_err), 32'd1);
    do_op(1'b0, 3'b000, 32'h100, 32'h0, 0, 1'b0, 0, 32'h1234_567F, 1'b0);
    chk("lb_pos_data", lsu.rsp_rdata, 32'h0000_007F);

    // Reset while waiting for read data, then a late rvalid
    lsu.req_valid  = 1'b1;
    lsu.req_write  = 1'b0;
    lsu.req_funct3 = 3'b010;
    lsu.addr       = 32'h300;
    step();
    lsu.req_valid = 1'b0;
    exp_ready     = 1'b0;
    exp_mem_req   = 1'b1;
    exp_mem_we    = 1'b0;
    exp_store     = 1'b0;
    exp_mem_addr  = 32'h300;
    lsu.mem_gnt   = 1'b1;
    step();
    lsu.mem_gnt = 1'b0;
    exp_mem_req = 1'b0;
    rst         = 1'b1;
    step();
    rst = 1'b0;
    set_exp_idle_reset();
    check_reset_values("wait_rst");
    lsu.mem_rvalid = 1'b1;
    lsu.mem_rdata  = 32'hFFFF_FFFF;
    step();
    lsu.mem_rvalid = 1'b0;
    step();
    do_op(1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 0, 1'b0, 0, 32'h0, 1'b0);
    chk("post_rst_addr", snap_addr, 32'h0000_0104);
    do_op(1'b0, 3'b010, 32'h104, 32'h0, 0, 1'b0, 0, 32'h0BAD_CAFE, 1'b0);
    chk("post_rst_data", lsu.rsp_rdata, 32'h0BAD_CAFE);

    step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
